// File: rtl/calc_scheduler.sv
// calc_scheduler: loads instructions from two round-robin requesters, then issues them as a looping program.
// Build option CALC_SCHED_FIXED_PRIO_EN: req0 always wins simultaneous offers.
module calc_scheduler #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_opCode,
  input  logic [3:0] req0_value,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_opCode,
  input  logic [3:0] req1_value,
  output logic       req1_ready,
  input  logic       start,
  input  logic       stop,
  output logic       issue_valid,
  output logic [2:0] issue_opCode,
  output logic [3:0] issue_value,
  input  logic       issue_ready,
  output logic       busy,
  output logic       cacheFull,
  output logic       invalidOp,
  output logic       last_grant
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CMPW = (CW > 4) ? CW : 4;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_nxt;

  logic [2:0]    op_mem  [DEPTH];
  logic [3:0]    val_mem [DEPTH];
  logic [CW-1:0] count;
  logic [AW-1:0] pc, loop_target;
  logic          last_grant_q, invalid_q;

  function automatic logic is_rejected(input logic [2:0] op);
    return op[1:0] == 2'b11;
  endfunction

  logic       grant_any, grant_sel;
  logic [2:0] sel_op;
  logic [3:0] sel_val;
  logic       store_en;

  assign cacheFull = (count == CW'(DEPTH));

  always_comb begin
    grant_any = 1'b0;
    grant_sel = last_grant_q;
    if (state == LOAD && !cacheFull) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
`ifdef CALC_SCHED_FIXED_PRIO_EN
        grant_sel = 1'b0;
`else
        grant_sel = ~last_grant_q;
`endif
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_sel = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_sel = 1'b1;
      end
    end
  end

  assign sel_op   = grant_sel ? req1_opCode : req0_opCode;
  assign sel_val  = grant_sel ? req1_value  : req0_value;
  assign store_en = grant_any && !is_rejected(sel_op);

  // Ready is gated by reset so every output is quiet while reset is held.
  assign req0_ready = reset && grant_any && !grant_sel;
  assign req1_ready = reset && grant_any &&  grant_sel;

  logic [2:0]    cur_op;
  logic [3:0]    cur_val;
  logic          is_jmp, advance;
  logic [AW-1:0] pc_nxt, jmp_target;

  assign cur_op     = op_mem[pc];
  assign cur_val    = val_mem[pc];
  assign is_jmp     = (cur_op == 3'b110);
  assign advance    = (state == RUN) && (is_jmp || issue_ready);
  assign pc_nxt     = (CW'(pc) == count - CW'(1)) ? loop_target : pc + AW'(1);
  assign jmp_target = (CMPW'(cur_val) >= CMPW'(count)) ? '0 : AW'(cur_val);

  assign busy         = (state == RUN);
  assign issue_valid  = reset && (state == RUN) && !is_jmp;
  assign issue_opCode = issue_valid ? cur_op  : 3'b000;
  assign issue_value  = issue_valid ? cur_val : 4'b0000;
  assign invalidOp    = invalid_q;
  assign last_grant   = last_grant_q;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (start && count != '0) state_nxt = RUN;
      // A stalled issue must finish its handshake before leaving RUN.
      RUN:  if (stop && (is_jmp || issue_ready)) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LOAD;
      count        <= '0;
      pc           <= '0;
      loop_target  <= '0;
      last_grant_q <= 1'b1;
      invalid_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      invalid_q <= grant_any && is_rejected(sel_op);
      if (grant_any) last_grant_q <= grant_sel;
      if (store_en) count <= count + CW'(1);
      if (state == LOAD && state_nxt == RUN) begin
        pc          <= '0;
        loop_target <= '0;
      end else if (advance) begin
        pc <= pc_nxt;
        if (is_jmp) loop_target <= jmp_target;
      end
    end
  end

  // Program storage carries no reset; count alone marks valid entries.
  always_ff @(posedge clk) begin
    if (store_en) begin
      op_mem[count[AW-1:0]]  <= sel_op;
      val_mem[count[AW-1:0]] <= sel_val;
    end
  end
endmodule

// File: tb/tb_calc_scheduler.sv
// Bench for calc_scheduler: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based program model.
module tb_calc_scheduler;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 0, req1_valid = 0;
  logic [2:0] req0_opCode = 0, req1_opCode = 0;
  logic [3:0] req0_value = 0, req1_value = 0;
  logic       req0_ready, req1_ready;
  logic       start = 0, stop = 0;
  logic       issue_valid;
  logic [2:0] issue_opCode;
  logic [3:0] issue_value;
  logic       issue_ready = 0;
  logic       busy, cacheFull, invalidOp, last_grant;

  int checks = 0;
  int errors = 0;

  calc_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_opCode(req0_opCode), .req0_value(req0_value), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_opCode(req1_opCode), .req1_value(req1_value), .req1_ready(req1_ready),
    .start(start), .stop(stop),
    .issue_valid(issue_valid), .issue_opCode(issue_opCode), .issue_value(issue_value), .issue_ready(issue_ready),
    .busy(busy), .cacheFull(cacheFull), .invalidOp(invalidOp), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the program is a list of (opcode, value); its length is the count.
  bit m_run = 0;
  int m_op[$];
  int m_val[$];
  int m_pc = 0, m_lt = 0;
  bit m_last = 1, m_inv = 0;

  always @(negedge clk) begin
    #3;
    if (!reset) begin
      m_run = 0; m_op.delete(); m_val.delete(); m_pc = 0; m_lt = 0; m_last = 1; m_inv = 0;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_issue_opCode", issue_opCode, 0);
      chk("rst_issue_value", issue_value, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cacheFull", cacheFull, 0);
      chk("rst_invalidOp", invalidOp, 0);
      chk("rst_last_grant", last_grant, 1);
    end else begin
      int cnt, g, op, e_iv;
      bit nxt_inv;
      cnt = m_op.size();
      g = -1;
      if (!m_run && cnt != DEPTH) begin
        if (req0_valid && req1_valid) begin
`ifdef CALC_SCHED_FIXED_PRIO_EN
          g = 0;
`else
          g = m_last ? 0 : 1;
`endif
        end else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
      end
      e_iv = (m_run && m_op[m_pc] != 6) ? 1 : 0;
      chk("m_req0_ready", req0_ready, g == 0);
      chk("m_req1_ready", req1_ready, g == 1);
      chk("m_busy", busy, m_run);
      chk("m_cacheFull", cacheFull, cnt == DEPTH);
      chk("m_invalidOp", invalidOp, m_inv);
      chk("m_last_grant", last_grant, m_last);
      chk("m_issue_valid", issue_valid, e_iv);
      if (e_iv != 0) begin
        chk("m_issue_opCode", issue_opCode, m_op[m_pc]);
        chk("m_issue_value", issue_value, m_val[m_pc]);
      end
      nxt_inv = 0;
      if (g >= 0) begin
        op = (g == 1) ? int'(req1_opCode) : int'(req0_opCode);
        m_last = (g == 1);
        if (op == 3 || op == 7) nxt_inv = 1;
        else begin
          m_op.push_back(op);
          m_val.push_back((g == 1) ? int'(req1_value) : int'(req0_value));
        end
      end
      if (!m_run) begin
        if (start && cnt > 0) begin m_run = 1; m_pc = 0; m_lt = 0; end
      end else begin
        bit jmp;
        int new_lt;
        jmp = (m_op[m_pc] == 6);
        if (stop && (jmp || issue_ready)) m_run = 0;
        else if (jmp || issue_ready) begin
          new_lt = (m_val[m_pc] >= cnt) ? 0 : m_val[m_pc];
          m_pc = (m_pc == cnt - 1) ? m_lt : m_pc + 1;
          if (jmp) m_lt = new_lt;
        end
      end
      m_inv = nxt_inv;
    end
  end

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_opCode = 0; req1_opCode = 0;
    req0_value = 0; req1_value = 0; start = 0; stop = 0; issue_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 0; idle_inputs();
    @(negedge clk); reset = 1;
  endtask

  initial begin
    int exp_g[4];
    int prog_op[4];
    int prog_val[4];
    int got_op[$];
    int got_val[$];
    int exp_op[5];
    int exp_val[5];
    int hold_op, hold_val, waited;

    // Reset with offers present: nothing may be granted.
    reset = 0; req0_valid = 1; req1_valid = 1;
    @(negedge clk); #3;
    chk("reset_ready0", req0_ready, 0);
    chk("reset_last_grant", last_grant, 1);

    // Both requesters valid for four cycles.
`ifdef CALC_SCHED_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); reset = 1; req0_valid = 1; req1_valid = 1;
      req0_opCode = 3'd0; req1_opCode = 3'd2; req0_value = 4'(i); req1_value = 4'(i);
      #3;
      chk("rr_ready0", req0_ready, exp_g[i] == 0);
      chk("rr_ready1", req1_ready, exp_g[i] == 1);
    end

    // Rejected opcode: handshake completes, invalidOp pulses once.
    @(negedge clk); req1_valid = 0; req0_valid = 1; req0_opCode = 3'b011; #3;
    chk("inv_ready0", req0_ready, 1);
    @(negedge clk); req0_valid = 0; #3;
    chk("inv_pulse", invalidOp, 1);
    chk("inv_not_full", cacheFull, 0);
    @(negedge clk); #3;
    chk("inv_pulse_end", invalidOp, 0);

    // Twelve more entries bring the count to sixteen; stop in LOAD is ignored.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); req0_valid = 1; req0_opCode = 3'd1; req0_value = 4'(i); stop = 1; #3;
      chk("fill_ready0", req0_ready, 1);
    end
    @(negedge clk); req0_valid = 1; req1_valid = 1; #3;
    chk("full_flag", cacheFull, 1);
    chk("full_ready0", req0_ready, 0);
    chk("full_ready1", req1_ready, 0);
    chk("stop_in_load_busy", busy, 0);

    // Looping program with a JMP back to entry 1.
    do_reset();
    prog_op = '{0, 6, 1, 5};
    prog_val = '{1, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req0_valid = 1; req0_opCode = 3'(prog_op[i]); req0_value = 4'(prog_val[i]);
    end
    @(negedge clk); req0_valid = 0; start = 1; #3;
    chk("start_cycle_busy", busy, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); start = 0; issue_ready = 1; #3;
      chk("run_busy", busy, 1);
      if (issue_valid) begin got_op.push_back(issue_opCode); got_val.push_back(issue_value); end
    end
    exp_op = '{0, 1, 5, 1, 5};
    exp_val = '{1, 2, 0, 2, 0};
    chk("issue_count_enough", got_op.size() >= 5, 1);
    for (int i = 0; i < 5 && i < got_op.size(); i++) begin
      chk("prog_op", got_op[i], exp_op[i]);
      chk("prog_val", got_val[i], exp_val[i]);
    end

    // Back-pressure: presented instruction holds steady.
    waited = 0;
    @(negedge clk); issue_ready = 0; #3;
    while (!issue_valid && waited < 5) begin
      @(negedge clk); #3; waited++;
    end
    chk("stall_found_issue", issue_valid, 1);
    hold_op = issue_opCode; hold_val = issue_value;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      chk("stall_valid", issue_valid, 1);
      chk("stall_opCode", issue_opCode, hold_op);
      chk("stall_value", issue_value, hold_val);
    end

    // Stop with a stalled issue waits for the handshake.
    @(negedge clk); stop = 1; #3;
    chk("stop_pending_busy", busy, 1);
    @(negedge clk); #3;
    chk("stop_pending_busy2", busy, 1);
    chk("stop_pending_valid", issue_valid, 1);
    @(negedge clk); issue_ready = 1; #3;
    @(negedge clk); stop = 0; issue_ready = 0; #3;
    chk("stop_done_busy", busy, 0);

    // Restart from the retained program, then reset clears the count.
    @(negedge clk); start = 1; #3;
    @(negedge clk); start = 0; #3;
    chk("restart_busy", busy, 1);
    @(negedge clk); reset = 0; #3;
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_valid", issue_valid, 0);
    @(negedge clk); reset = 1; start = 1; #3;
    @(negedge clk); #3;
    chk("empty_start_ignored", busy, 0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 79) != 0);
      req0_valid = $urandom_range(0, 1); req1_valid = $urandom_range(0, 1);
      req0_opCode = 3'($urandom_range(0, 7)); req1_opCode = 3'($urandom_range(0, 7));
      req0_value = 4'($urandom_range(0, 15)); req1_value = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 29) == 0);
      issue_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk); idle_inputs(); #4;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_scheduler.md
CALC_SCHEDULER -- requirements
Module: calc_scheduler

Interface
REQ-001 Parameter DEPTH, default 16: program buffer entries; power of two, 4..32.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 req0_valid / req1_valid  input  1 each  requester N offers an instruction.
REQ-005 req0_opCode / req1_opCode  input  3 each  offered opcode.
REQ-006 req0_value / req1_value  input  4 each  offered operand.
REQ-007 req0_ready / req1_ready  output  1 each  offer from requester N accepted this cycle.
REQ-008 start  input  1  level; begin execution when in LOAD.
REQ-009 stop  input  1  level; end execution when in RUN.
REQ-010 issue_valid  output  1  instruction presented to the datapath.
REQ-011 issue_opCode  output  3  presented opcode.
REQ-012 issue_value  output  4  presented operand.
REQ-013 issue_ready  input  1  datapath consumes the presented instruction.
REQ-014 busy  output  1  high in RUN.
REQ-015 cacheFull  output  1  buffer holds DEPTH entries.
REQ-016 invalidOp  output  1  one-cycle pulse on a rejected opcode.
REQ-017 last_grant  output  1  index of the most recently accepted requester.

Function
REQ-018 The FSM SHALL have exactly two states, LOAD and RUN, with LOAD on reset.
REQ-019 In LOAD, with cacheFull low, one requester SHALL be granted per cycle: ready high, same-cycle combinational on valid.
REQ-020 Grant SHALL be round-robin: when both valid, grant the requester not equal to last_grant.
REQ-021 Accepted opcodes 011 and 111 SHALL complete the handshake, not be stored, and pulse invalidOp the next cycle.
REQ-022 Other accepted opcodes SHALL be written at index count; count increments; cacheFull = (count == DEPTH).
REQ-023 With cacheFull high or in RUN, both ready outputs SHALL be 0.
REQ-024 LOAD -> RUN SHALL occur when start = 1 and count > 0; start with count = 0 is ignored.
REQ-025 On entering RUN, pc = 0 and loop_target = 0.
REQ-026 In RUN, entry pc with opcode 110 (JMP) SHALL NOT be issued; it sets loop_target = value (0 if value >= count) and advances pc in one cycle.
REQ-027 Non-JMP entries SHALL drive issue_valid with the entry's opcode and value, held stable until issue_ready is 1.
REQ-028 pc SHALL advance on the issue_valid && issue_ready cycle; pc == count-1 wraps to loop_target.
REQ-029 With stop = 1 in RUN, the FSM SHALL finish any pending handshake, then return to LOAD with the buffer and count retained.
REQ-030 A program of only JMP entries SHALL loop without issuing; stop still terminates it.
REQ-031 Asserting start in RUN, or stop in LOAD, SHALL have no effect.

Reset
REQ-032 With reset = 0: state = LOAD; count, pc, loop_target = 0; last_grant = 1.
REQ-033 With reset = 0, all outputs SHALL be 0, with last_grant = 1.
REQ-034 Reset mid-RUN SHALL abandon any pending issue.
REQ-035 Buffer contents need not be cleared; count = 0 invalidates them.

Configuration
REQ-036 Macro CALC_SCHED_FIXED_PRIO_EN: when defined, req0 always wins simultaneous requests and last_grant still updates; when undefined, REQ-020 round-robin applies.

Verification
REQ-037 After reset, req0 and req1 both valid for 4 cycles -> grants alternate 0,1,0,1; count = 4.
REQ-038 req0 offers opCode 011 -> req0_ready = 1, invalidOp pulses 1 cycle, count unchanged.
REQ-039 Fill 16 entries -> cacheFull = 1; a 17th offer sees ready = 0.
REQ-040 Program {000/1, 110/1, 001/2, 101/0}, start, issue_ready = 1 -> issues 000/1, 001/2, 101/0, 001/2, 101/0, ...
REQ-041 issue_ready held 0 for 3 cycles mid-RUN -> issue_opCode/value stable; pc unchanged.
REQ-042 stop during RUN, then reset = 0 -> busy = 0, LOAD, count = 0.
